// File: rtl/eggtimer_pkg.sv
// Shared definitions for the egg timer front end: repeat FSM states and default timing.
package eggtimer_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } RepeatState;

  localparam int DEFAULT_CHANNELS      = 4;
  localparam int DEFAULT_STABLE_CYCLES = 64;
  localparam int DEFAULT_HOLD_CYCLES   = 5000000;
  localparam int DEFAULT_REPEAT_CYCLES = 1250000;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, edge debounce counter, strobes and auto-repeat FSM.
module button_channel
  import eggtimer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_button,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DebWidth  = $clog2(STABLE_CYCLES + 1);
  localparam int HoldWidth = $clog2(maxInt(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [DebWidth-1:0]  DebLast    = DebWidth'(STABLE_CYCLES - 1);
  localparam logic [HoldWidth-1:0] HoldLast   = HoldWidth'(HOLD_CYCLES - 1);
  localparam logic [HoldWidth-1:0] RepeatLast = HoldWidth'(REPEAT_CYCLES - 1);

  logic                 r_syncMeta;
  logic                 r_syncOut;
  logic [DebWidth-1:0]  r_debCount;
  logic                 r_level;
  logic                 r_press;
  logic                 r_release;
  logic                 r_repeat;
  RepeatState           r_state;
  RepeatState           w_nextState;
  logic [HoldWidth-1:0] r_holdCount;
  logic [HoldWidth-1:0] w_nextHoldCount;
  logic                 w_differs;
  logic                 w_flip;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_holdDone;
  logic                 w_repeatDone;
  logic                 w_repeatPulse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_syncMeta <= 1'b0;
      r_syncOut  <= 1'b0;
    end else begin
      r_syncMeta <= i_button;
      r_syncOut  <= r_syncMeta;
    end
  end

  // The level flips only after STABLE_CYCLES consecutive samples disagree with it.
  assign w_differs = (r_syncOut != r_level);
  assign w_flip    = w_differs && (r_debCount == DebLast);
  assign w_rise    = w_flip && r_syncOut;
  assign w_fall    = w_flip && !r_syncOut;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_debCount <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      if (!w_differs || w_flip) begin
        r_debCount <= '0;
      end else begin
        r_debCount <= r_debCount + 1'b1;
      end
      if (w_flip) begin
        r_level <= r_syncOut;
      end
    end
  end

  assign w_holdDone   = (r_holdCount == HoldLast);
  assign w_repeatDone = (r_holdCount == RepeatLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RELEASED;
      r_holdCount <= '0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_holdCount <= w_nextHoldCount;
      r_repeat    <= w_repeatPulse;
    end
  end

  // A falling level overrides everything else so a release never carries a repeat.
  always_comb begin
    w_nextState     = r_state;
    w_nextHoldCount = '0;
    if (w_fall) begin
      w_nextState = RELEASED;
    end else begin
      case (r_state)
        RELEASED: begin
          if (w_rise) begin
            w_nextState = PRESSED;
          end
        end
        PRESSED: begin
          if (i_repeat_en) begin
            if (w_holdDone) begin
              w_nextState = REPEATING;
            end else begin
              w_nextHoldCount = r_holdCount + 1'b1;
            end
          end
        end
        REPEATING: begin
          if (!i_repeat_en) begin
            w_nextState = PRESSED;
          end else if (!w_repeatDone) begin
            w_nextHoldCount = r_holdCount + 1'b1;
          end
        end
        default: begin
          w_nextState = RELEASED;
        end
      endcase
    end
  end

  always_comb begin
    w_repeatPulse = 1'b0;
    if (!w_fall && i_repeat_en) begin
      case (r_state)
        PRESSED:   w_repeatPulse = w_holdDone;
        REPEATING: w_repeatPulse = w_repeatDone;
        default:   w_repeatPulse = 1'b0;
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: one independent button_channel per input pin.
module button_conditioner
  import eggtimer_pkg::*;
#(
  parameter int CHANNELS      = DEFAULT_CHANNELS,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] i_button,
  input  logic [CHANNELS-1:0] i_repeat_en,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_repeat
);

  if (CHANNELS < 1) begin : g_badChannels
    $error("button_conditioner: CHANNELS must be at least 1");
  end
  if (STABLE_CYCLES < 1) begin : g_badStable
    $error("button_conditioner: STABLE_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_badHold
    $error("button_conditioner: HOLD_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_badRepeat
    $error("button_conditioner: REPEAT_CYCLES must be at least 1");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    button_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_button   (i_button[c]),
      .i_repeat_en(i_repeat_en[c]),
      .o_level    (o_level[c]),
      .o_press    (o_press[c]),
      .o_release  (o_release[c]),
      .o_repeat   (o_repeat[c])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner against a sample-history reference model.
module tb_button_conditioner;

  localparam int CH   = 2;
  localparam int S    = 4;
  localparam int H    = 8;
  localparam int R    = 3;
  localparam int MAXE = 4096;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] i_button;
  logic [CH-1:0] i_repeat_en;
  logic [CH-1:0] o_level;
  logic [CH-1:0] o_press;
  logic [CH-1:0] o_release;
  logic [CH-1:0] o_repeat;

  int nChecks = 0;
  int nBad    = 0;
  int edgeIdx = 0;

  bit            hist[CH][MAXE];
  logic [CH-1:0] mLevel, mPress, mRelease, mRepeat;
  int            holdStart[CH];
  int            pressEdges[$];
  int            relEdges[$];
  int            repEdges[$];
  int            ch1Events;

  always #5 clk = ~clk;

  button_conditioner #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_button   (i_button),
    .i_repeat_en(i_repeat_en),
    .o_level    (o_level),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_repeat   (o_repeat)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edgeIdx, got, exp);
    end
  endtask

  function automatic bit histAt(input int c, input int t);
    return (t < 1) ? 1'b0 : hist[c][t];
  endfunction

  task automatic modelReset();
    edgeIdx  = 0;
    mLevel   = '0;
    mPress   = '0;
    mRelease = '0;
    mRepeat  = '0;
    for (int c = 0; c < CH; c++) holdStart[c] = -1;
    pressEdges.delete();
    relEdges.delete();
    repEdges.delete();
    ch1Events = 0;
  endtask

  // Level flips once the last S synchronised samples (button seen 2..S+1 edges ago) all oppose it.
  // Repeats fire H-1 edges into a continuous enabled hold, then every R edges after that.
  task automatic modelEdge();
    bit allOpp;
    int d;
    edgeIdx++;
    if (edgeIdx >= MAXE) begin
      $display("[TB] FAIL edgeLimit: got %0d expected below %0d", edgeIdx, MAXE);
      $fatal(1, "[TB] model history exhausted");
    end
    for (int c = 0; c < CH; c++) begin
      hist[c][edgeIdx] = i_button[c];
      mPress[c]   = 1'b0;
      mRelease[c] = 1'b0;
      mRepeat[c]  = 1'b0;
      allOpp = 1'b1;
      for (int i = 2; i <= S + 1; i++) begin
        if (histAt(c, edgeIdx - i) == mLevel[c]) allOpp = 1'b0;
      end
      if (allOpp) begin
        mLevel[c]    = ~mLevel[c];
        mPress[c]    = mLevel[c];
        mRelease[c]  = ~mLevel[c];
        holdStart[c] = -1;
      end else if (mLevel[c]) begin
        if (i_repeat_en[c]) begin
          if (holdStart[c] < 0) holdStart[c] = edgeIdx;
          d = edgeIdx - holdStart[c];
          mRepeat[c] = (d >= H - 1) && (((d - (H - 1)) % R) == 0);
        end else begin
          holdStart[c] = -1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] b, input logic [CH-1:0] e);
    i_button    = b;
    i_repeat_en = e;
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput("level",   int'(o_level),   int'(mLevel));
    checkOutput("press",   int'(o_press),   int'(mPress));
    checkOutput("release", int'(o_release), int'(mRelease));
    checkOutput("repeat",  int'(o_repeat),  int'(mRepeat));
    if (o_press[0])   pressEdges.push_back(edgeIdx);
    if (o_release[0]) relEdges.push_back(edgeIdx);
    if (o_repeat[0])  repEdges.push_back(edgeIdx);
    if (o_level[1] || o_press[1] || o_release[1] || o_repeat[1]) ch1Events++;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncLevel",   int'(o_level), 0);
    checkOutput("asyncStrobes", int'({o_press, o_release, o_repeat}), 0);
    i_button    = '0;
    i_repeat_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [CH-1:0] b;
    logic [CH-1:0] e;
    int            remaining[CH];
    int            pick;

    reset_n     = 1'b0;
    i_button    = 2'b11;
    i_repeat_en = 2'b00;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstLevel",   int'(o_level),   0);
    checkOutput("rstPress",   int'(o_press),   0);
    checkOutput("rstRelease", int'(o_release), 0);
    checkOutput("rstRepeat",  int'(o_repeat),  0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(2'b11, 2'b00);
      if (k == 5) checkOutput("levelBeforeSixth", int'(o_level), 0);
      if (k == 6) begin
        checkOutput("pressAtSixth",   int'(o_press),   3);
        checkOutput("noReleaseSixth", int'(o_release), 0);
      end
    end

    // Bounce rejection, then a clean press and a clean release on channel 0.
    resetDut();
    for (int k = 1; k <= 16; k++) applyStimulus((k == 4) ? 2'b00 : 2'b01, 2'b00);
    checkOutput("bouncePressCount", pressEdges.size(), 1);
    checkOutput("bouncePressEdge", (pressEdges.size() > 0) ? pressEdges[0] : -1, 10);
    for (int k = 17; k <= 26; k++) applyStimulus(2'b00, 2'b00);
    checkOutput("releaseCount", relEdges.size(), 1);
    checkOutput("releaseEdge", (relEdges.size() > 0) ? relEdges[0] : -1, 22);
    checkOutput("releaseNoRepeat", repEdges.size(), 0);

    // Auto-repeat on channel 0 while channel 1 chatters every cycle.
    resetDut();
    for (int k = 1; k <= 28; k++) begin
      b[0] = (k <= 17);
      b[1] = k[0];
      applyStimulus(b, 2'b11);
    end
    checkOutput("repPressEdge", (pressEdges.size() > 0) ? pressEdges[0] : -1, 6);
    checkOutput("repCount", repEdges.size(), 3);
    checkOutput("rep1", (repEdges.size() > 0) ? repEdges[0] : -1, 14);
    checkOutput("rep2", (repEdges.size() > 1) ? repEdges[1] : -1, 17);
    checkOutput("rep3", (repEdges.size() > 2) ? repEdges[2] : -1, 20);
    checkOutput("releaseOnRepeatEdge", (relEdges.size() > 0) ? relEdges[0] : -1, 23);
    checkOutput("ch1Quiet", ch1Events, 0);

    // Repeat gating: hold without enable, then enable mid-press.
    resetDut();
    for (int k = 1; k <= 40; k++) applyStimulus(2'b01, (k >= 27) ? 2'b01 : 2'b00);
    checkOutput("gatedCount", repEdges.size(), 3);
    checkOutput("gatedFirst", (repEdges.size() > 0) ? repEdges[0] : -1, 34);

    // Randomised runs of mixed bounces and long holds with a toggling enable.
    for (int seg = 0; seg < 3; seg++) begin
      resetDut();
      b = '0;
      e = CH'($urandom);
      for (int c = 0; c < CH; c++) remaining[c] = 1;
      for (int n = 0; n < 1200; n++) begin
        for (int c = 0; c < CH; c++) begin
          remaining[c]--;
          if (remaining[c] <= 0) begin
            b[c] = ~b[c];
            remaining[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S + 1))
                                                        : int'($urandom_range(S, 40));
          end
        end
        if ($urandom_range(0, 15) == 0) begin
          pick = int'($urandom_range(0, CH - 1));
          e[pick] = ~e[pick];
        end
        applyStimulus(b, e);
      end
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
